// File: rtl/pattern_mem_arbiter_if.sv
// Bus bundle tying the pattern memory arbiter to the video fetcher, the CPU port and the pattern RAM.
interface pattern_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int WAIT_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              starve;
  logic [WAIT_W-1:0] wait_max;

  // Arbiter side: consumes requests and RAM read data, drives everything else.
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_valid, vid_data, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata,
           starve, wait_max
  );

  // Requester/RAM side: the mirror image of the arbiter view.
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_valid, vid_data, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata,
           starve, wait_max
  );
endinterface

// File: rtl/pattern_mem_arbiter.sv
// Shares one single-port pattern RAM between the hard real-time video tile fetcher (always wins)
// and the CPU port (req/ack, idle slots only), and tracks how long the CPU is kept waiting.
module pattern_mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int RD_LAT       = 1,
  parameter int WAIT_W       = 8,
  parameter int STARVE_LIMIT = 200
) (
  input logic                  clk,
  input logic                  rst_n,
  pattern_mem_arbiter_if.slave bus
);

  localparam int                CNT_W      = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0]  RD_LAT_CNT = CNT_W'(RD_LAT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;
  localparam logic [WAIT_W-1:0] STARVE_THR = WAIT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} cpu_state_t;

  cpu_state_t        state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [RD_LAT:0]   vid_tag;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              vid_win;
  logic              cpu_win;
  logic [ADDR_W-1:0] grant_addr;

  // Fixed-priority grant: video first, CPU only when nothing of its own is outstanding.
  always_comb begin
    vid_win    = bus.vid_req;
    cpu_win    = !bus.vid_req && (state == IDLE) && bus.cpu_req;
    grant_addr = vid_win ? bus.vid_addr : bus.cpu_addr;
  end

  // Next CPU wait length: grows only while an idle CPU is blocked by video, saturating.
  always_comb begin
    wait_next = wait_cnt;
    if (!bus.cpu_req || cpu_win) begin
      wait_next = '0;
    end else if ((state == IDLE) && vid_win && (wait_cnt != WAIT_SAT)) begin
      wait_next = wait_cnt + 1'b1;
    end
  end

  // Register the winner onto the RAM port; with no winner the address is left where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (vid_win || cpu_win) begin
        bus.mem_addr <= grant_addr;
      end
      if (cpu_win && bus.cpu_we) begin
        bus.mem_we    <= 1'b1;
        bus.mem_wdata <= bus.cpu_wdata;
      end
    end
  end

  // Tag each video issue and return its read word RD_LAT+1 cycles later, in issue order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_tag       <= '0;
      bus.vid_valid <= 1'b0;
      bus.vid_data  <= '0;
    end else begin
      vid_tag       <= {vid_tag[RD_LAT-1:0], vid_win};
      bus.vid_valid <= vid_tag[RD_LAT];
      if (vid_tag[RD_LAT]) begin
        bus.vid_data <= bus.mem_rdata;
      end
    end
  end

  // CPU access sequencer: one access at a time, ACK registered, read word captured as it returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_win) begin
            if (bus.cpu_we) begin
              state       <= WR_ACK;
              bus.cpu_ack <= 1'b1;
            end else begin
              state  <= RD_WAIT;
              rd_cnt <= RD_LAT_CNT;
            end
          end
        end
        WR_ACK: state <= IDLE;
        RD_WAIT: begin
          if (rd_cnt == '0) begin
            state         <= RD_ACK;
            bus.cpu_ack   <= 1'b1;
            bus.cpu_rdata <= DATA_W'(bus.mem_rdata);
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        RD_ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation tracking; STARVE and WAIT_MAX follow the wait length as it is stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      bus.starve   <= 1'b0;
      bus.wait_max <= '0;
    end else begin
      wait_cnt   <= wait_next;
      bus.starve <= (wait_next >= STARVE_THR);
      if (wait_next > bus.wait_max) begin
        bus.wait_max <= wait_next;
      end
    end
  end

endmodule

// File: tb/tb_pattern_mem_arbiter.sv
// Self-checking bench for pattern_mem_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized phase compared against a cycle-numbered transaction model.
module tb_pattern_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int WAIT_W = 8;
  localparam int N_RND  = 800;
  localparam int NEVER  = 32'h3FFF_FFFF;

  typedef struct {
    logic        vr;
    logic [11:0] va;
    logic        cr;
    logic        cw;
    logic [11:0] ca;
    logic [15:0] cd;
    logic        e_vv;
    logic [15:0] e_vd;
    logic        e_ack;
    logic [15:0] e_rd;
    logic        e_we;
    logic [7:0]  e_wmax;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [DATA_W-1:0] ram     [0:4095];
  bit                wr_mark [0:4095];

  pattern_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W)) bus ();

  pattern_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .WAIT_W(WAIT_W), .STARVE_LIMIT(200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] initWord(input logic [11:0] a);
    return 16'(a) + 16'h0100;
  endfunction

  // Pattern RAM with one cycle of read latency; unwritten words read as addr+0x100.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr]     <= bus.mem_wdata;
      wr_mark[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= wr_mark[bus.mem_addr] ? ram[bus.mem_addr] : initWord(bus.mem_addr);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic vr, input logic [11:0] va, input logic cr,
                              input logic cw, input logic [11:0] ca, input logic [15:0] cd,
                              input logic evv, input logic [15:0] evd, input logic eack,
                              input logic [15:0] erd, input logic ewe, input logic [7:0] ewm);
    vec_t v;
    v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.e_vv = evv; v.e_vd = evd; v.e_ack = eack; v.e_rd = erd; v.e_we = ewe; v.e_wmax = ewm;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.vid_req   = v.vr;
    bus.vid_addr  = v.va;
    bus.cpu_req   = v.cr;
    bus.cpu_we    = v.cw;
    bus.cpu_addr  = v.ca;
    bus.cpu_wdata = v.cd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
    checkOutput({tag, "_vid_data"},  32'(bus.vid_data),  32'd0);
    checkOutput({tag, "_cpu_ack"},   32'(bus.cpu_ack),   32'd0);
    checkOutput({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
    checkOutput({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    checkOutput({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    checkOutput({tag, "_starve"},    32'(bus.starve),    32'd0);
    checkOutput({tag, "_wait_max"},  32'(bus.wait_max),  32'd0);
  endtask

  vec_t tab [19];
  vec_t idle_v;

  // Random-phase reference model state (cycle-numbered expectations).
  logic [15:0] vexp   [int];
  logic [15:0] cexp   [int];
  bit          wexp   [int];
  logic [15:0] shadow [int];

  function automatic logic [15:0] memWord(input logic [11:0] a);
    return shadow.exists(a) ? shadow[a] : initWord(a);
  endfunction

  initial begin
    vec_t v;
    int   early, hits, ack_at, first, rises, wm, st, ack_seen, vv_seen, prev;
    int   free_c, w, exp_wmax, pend;
    bit   exp_starve, granted;
    logic [15:0] got, last_rd;

    total = 0;
    bad   = 0;
    idle_v = mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000,
                1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);

    // rows: inputs for cycle i, outputs expected in cycle i
    tab[0]  = mk(1'b1, 12'h001, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[1]  = mk(1'b1, 12'h002, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[2]  = mk(1'b1, 12'h003, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[3]  = mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 16'h0101, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[4]  = mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 16'h0102, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[5]  = mk(1'b0, 12'h000, 1'b1, 1'b1, 12'h0A5, 16'hBEEF, 1'b1, 16'h0103, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[6]  = mk(1'b0, 12'h000, 1'b1, 1'b1, 12'h0A5, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 8'd0);
    tab[7]  = mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[8]  = mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[9]  = mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
    tab[10] = mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 8'd0);
    tab[11] = mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'd0);
    tab[12] = mk(1'b1, 12'h0A5, 1'b1, 1'b0, 12'h002, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'd0);
    tab[13] = mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h002, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'd1);
    tab[14] = mk(1'b1, 12'h010, 1'b1, 1'b0, 12'h002, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'd1);
    tab[15] = mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h002, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 8'd1);
    tab[16] = mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h002, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b0, 8'd1);
    tab[17] = mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 16'h0110, 1'b0, 16'h0102, 1'b0, 8'd1);
    tab[18] = mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0102, 1'b0, 8'd1);

    // Reset state
    rst_n = 1'b0;
    applyStimulus(idle_v);
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: video burst, CPU write/read, collision and overlap
    for (int i = 0; i < 19; i++) begin
      nextCycle();
      checkOutput($sformatf("tab%0d_vid_valid", i), 32'(bus.vid_valid), 32'(tab[i].e_vv));
      if (tab[i].e_vv)
        checkOutput($sformatf("tab%0d_vid_data", i), 32'(bus.vid_data), 32'(tab[i].e_vd));
      checkOutput($sformatf("tab%0d_cpu_ack", i),   32'(bus.cpu_ack),   32'(tab[i].e_ack));
      checkOutput($sformatf("tab%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(tab[i].e_rd));
      checkOutput($sformatf("tab%0d_mem_we", i),    32'(bus.mem_we),    32'(tab[i].e_we));
      checkOutput($sformatf("tab%0d_wait_max", i),  32'(bus.wait_max),  32'(tab[i].e_wmax));
      checkOutput($sformatf("tab%0d_starve", i),    32'(bus.starve),    32'd0);
      applyStimulus(tab[i]);
    end

    // 50 cycles of video with a CPU read pending: grant at 50, ACK at 53
    early = 0; hits = 0; ack_at = -1; got = '0;
    for (int k = 0; k < 50; k++) begin
      nextCycle();
      if (bus.cpu_ack) early++;
      if (bus.starve) hits++;
      v = idle_v; v.vr = 1'b1; v.va = 12'(k); v.cr = 1'b1; v.ca = 12'h0A5;
      applyStimulus(v);
    end
    for (int k = 50; k < 64; k++) begin
      nextCycle();
      if (bus.starve) hits++;
      if (bus.cpu_ack && ack_at < 0) begin
        ack_at = k;
        got    = bus.cpu_rdata;
      end
      v = idle_v; v.cr = (ack_at < 0); v.ca = 12'h0A5;
      applyStimulus(v);
    end
    checkOutput("t3_early_ack", 32'(early), 32'd0);
    checkOutput("t3_ack_cycle", 32'(ack_at), 32'd53);
    checkOutput("t3_rdata", 32'(got), 32'hBEEF);
    checkOutput("t3_wait_max", 32'(bus.wait_max), 32'd50);
    checkOutput("t3_starve", 32'(hits), 32'd0);

    // 300 cycles of video with CPU waiting: STARVE rises at wait 200, WAIT_MAX sticks at 255
    first = -1; rises = 0; prev = 0;
    for (int k = 0; k < 300; k++) begin
      nextCycle();
      if (bus.starve && first < 0) first = k;
      if (bus.starve && prev == 0) rises++;
      prev = int'(bus.starve);
      v = idle_v; v.vr = 1'b1; v.va = 12'(k); v.cr = 1'b1; v.ca = 12'h003;
      applyStimulus(v);
    end
    ack_at = -1; got = '0;
    for (int k = 300; k < 314; k++) begin
      nextCycle();
      if (k == 300) begin
        wm = int'(bus.wait_max);
        st = int'(bus.starve);
      end
      if (bus.cpu_ack && ack_at < 0) begin
        ack_at = k;
        got    = bus.cpu_rdata;
      end
      v = idle_v; v.cr = (ack_at < 0); v.ca = 12'h003;
      applyStimulus(v);
    end
    checkOutput("t4_first_starve", 32'(first), 32'd200);
    checkOutput("t4_starve_rises", 32'(rises), 32'd1);
    checkOutput("t4_wait_max_sat", 32'(wm), 32'd255);
    checkOutput("t4_starve_held", 32'(st), 32'd1);
    checkOutput("t4_ack_cycle", 32'(ack_at), 32'd303);
    checkOutput("t4_rdata", 32'(got), 32'h0103);
    checkOutput("t4_starve_cleared", 32'(bus.starve), 32'd0);
    checkOutput("t4_wait_max_kept", 32'(bus.wait_max), 32'd255);

    // Reset in the middle of a CPU read with a video read also in flight
    nextCycle();
    v = idle_v; v.vr = 1'b1; v.va = 12'h020;
    applyStimulus(v);
    nextCycle();
    v = idle_v; v.cr = 1'b1; v.ca = 12'h004;
    applyStimulus(v);
    nextCycle();
    #2;
    rst_n = 1'b0;
    applyStimulus(idle_v);
    #1;
    checkAllZero("t5");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 0; vv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      if (bus.cpu_ack) ack_seen++;
      if (bus.vid_valid) vv_seen++;
    end
    checkOutput("t5_no_cpu_ack", 32'(ack_seen), 32'd0);
    checkOutput("t5_no_vid_valid", 32'(vv_seen), 32'd0);

    // Random traffic (alternating video first, then random density) against the model
    free_c = 0; w = 0; exp_wmax = 0; exp_starve = 1'b0; last_rd = '0; pend = NEVER;
    v = idle_v;
    for (int c = 0; c < N_RND + 10; c++) begin
      nextCycle();
      checkOutput("rnd_vid_valid", 32'(bus.vid_valid), 32'(vexp.exists(c)));
      if (vexp.exists(c)) checkOutput("rnd_vid_data", 32'(bus.vid_data), 32'(vexp[c]));
      checkOutput("rnd_cpu_ack", 32'(bus.cpu_ack), 32'(cexp.exists(c)));
      if (cexp.exists(c)) checkOutput("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(cexp[c]));
      checkOutput("rnd_mem_we", 32'(bus.mem_we), 32'(wexp.exists(c)));
      checkOutput("rnd_starve", 32'(bus.starve), 32'(exp_starve));
      checkOutput("rnd_wait_max", 32'(bus.wait_max), 32'(exp_wmax));

      if (c >= N_RND)     v.vr = 1'b0;
      else if (c < 300)   v.vr = (c % 2 == 1);
      else                v.vr = ($urandom_range(0, 99) < 40);
      v.va = 12'h100 + 12'($urandom_range(0, 31));
      if (!v.cr) begin
        if (c < N_RND && $urandom_range(0, 3) == 0) begin
          v.cr = 1'b1; v.cw = 1'($urandom_range(0, 1));
          v.ca = 12'h100 + 12'($urandom_range(0, 31)); v.cd = 16'($urandom);
          pend = NEVER;
        end
      end else if (c > pend) begin
        if (c >= N_RND || $urandom_range(0, 1) == 0) begin
          v.cr = 1'b0;
        end else begin
          v.cw = 1'($urandom_range(0, 1));
          v.ca = 12'h100 + 12'($urandom_range(0, 31)); v.cd = 16'($urandom);
        end
        pend = NEVER;
      end
      applyStimulus(v);

      granted = !v.vr && v.cr && (c >= free_c);
      if (!v.cr || granted) w = 0;
      else if (v.vr && (c >= free_c) && (w < 255)) w++;
      if (v.vr) vexp[c + 3] = memWord(v.va);
      if (granted) begin
        if (v.cw) begin
          shadow[v.ca] = v.cd;
          wexp[c + 1]  = 1'b1;
          cexp[c + 1]  = last_rd;
          free_c = c + 2;
          pend   = c + 1;
        end else begin
          last_rd     = memWord(v.ca);
          cexp[c + 3] = last_rd;
          free_c = c + 4;
          pend   = c + 3;
        end
      end
      exp_starve = (w >= 200);
      if (w > exp_wmax) exp_wmax = w;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
